// File: rtl/uc_pkg.sv
// Shared constants, state encoding and control bundle for the microcontroller
// control unit and its instruction decoder.
package uc_pkg;

   localparam logic [5:0] OP_LI   = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000100;
   localparam logic [5:0] OP_JZ   = 6'b000101;
   localparam logic [5:0] OP_JNZ  = 6'b000110;
   localparam logic [5:0] OP_HALT = 6'b000111;
   localparam int         OP_ALU_BIT = 5;

   localparam logic [2:0] ALU_PASS_A = 3'b000;
   localparam logic [2:0] ALU_NOT_A  = 3'b001;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_NEG_A  = 3'b110;
   localparam logic [2:0] ALU_NEG_B  = 3'b111;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STEP_EXEC = 2'd2,
      HALTED    = 2'd3
   } uc_state_e;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we3;
      logic       wez;
      logic [2:0] op;
      logic       is_halt;
   } uc_ctrl_t;

   // Safe control word: no writes, PC sequential, ALU idle.
   function automatic uc_ctrl_t uc_idle_ctrl();
      uc_ctrl_t c;
      c.s_inc   = 1'b1;
      c.s_inm   = 1'b0;
      c.we3     = 1'b0;
      c.wez     = 1'b0;
      c.op      = ALU_PASS_A;
      c.is_halt = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/uc_decod.sv
// Combinational instruction decoder: opcode and zero flag to datapath controls.
module uc_decod
   import uc_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic       i_z,
   output uc_ctrl_t   o_ctrl
);

   always_comb begin
      o_ctrl = uc_idle_ctrl();
      if (i_opcode[OP_ALU_BIT]) begin
         o_ctrl.op  = i_opcode[4:2];
         o_ctrl.we3 = 1'b1;
         o_ctrl.wez = 1'b1;
      end else begin
         case (i_opcode)
            OP_LI: begin
               o_ctrl.s_inm = 1'b1;
               o_ctrl.we3   = 1'b1;
            end
            OP_J:    o_ctrl.s_inc   = 1'b0;
            OP_JZ:   o_ctrl.s_inc   = ~i_z;
            OP_JNZ:  o_ctrl.s_inc   = i_z;
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: o_ctrl.s_inc   = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/uc_ciclo.sv
// Sequencing control unit: run / single-step / halt FSM around the decoder,
// with PC hold, step acknowledge and a retired-instruction counter.
module uc_ciclo
   import uc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   input  logic             run,
   input  logic             step,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             pc_hold,
   output logic             halted,
   output logic             step_ack,
   output logic [CNT_W-1:0] icount
);

   uc_state_e        r_state, w_next;
   logic             r_step_prev;
   logic             r_step_ack;
   logic [CNT_W-1:0] r_icount;
   uc_ctrl_t         w_dec;
   logic             w_exec;
   logic             w_step_rise;

   uc_decod u_decod (
      .i_opcode (Opcode),
      .i_z      (z),
      .o_ctrl   (w_dec)
   );

   assign w_step_rise = step & ~r_step_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_exec = 1'b0;
      case (r_state)
         IDLE: begin
            if (run)              w_next = RUN;
            else if (w_step_rise) w_next = STEP_EXEC;
         end
         RUN: begin
            if (run) begin
               w_exec = 1'b1;
               w_next = w_dec.is_halt ? HALTED : RUN;
            end else begin
               w_next = IDLE;
            end
         end
         STEP_EXEC: begin
            w_exec = 1'b1;
            w_next = w_dec.is_halt ? HALTED : IDLE;
         end
         HALTED:  w_next = HALTED;
         default: w_next = IDLE;
      endcase
   end

   // Step edge history is tracked in every state so edges seen elsewhere are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_step_prev <= 1'b0;
         r_step_ack  <= 1'b0;
         r_icount    <= '0;
      end else begin
         r_step_prev <= step;
         r_step_ack  <= (r_state == STEP_EXEC);
         if (w_exec) r_icount <= r_icount + 1'b1;
      end
   end

   always_comb begin
      s_inc   = 1'b1;
      s_inm   = 1'b0;
      we3     = 1'b0;
      wez     = 1'b0;
      Op      = ALU_PASS_A;
      pc_hold = 1'b1;
      if (w_exec) begin
         s_inc   = w_dec.s_inc;
         s_inm   = w_dec.s_inm;
         we3     = w_dec.we3;
         wez     = w_dec.wez;
         Op      = w_dec.op;
         pc_hold = w_dec.is_halt;
      end
   end

   assign halted   = (r_state == HALTED);
   assign step_ack = r_step_ack;
   assign icount   = r_icount;

endmodule

// File: tb/tb_uc_ciclo.sv
module tb_uc_ciclo;

   localparam int CW = 4;
   localparam int W  = 10 + CW;
   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    Opcode = '0;
   logic          z = 1'b0, run = 1'b0, step = 1'b0;
   logic          s_inc, s_inm, we3, wez, pc_hold, halted, step_ack;
   logic [2:0]    Op;
   logic [CW-1:0] icount;

   uc_ciclo #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
      .pc_hold(pc_hold), .halted(halted), .step_ack(step_ack), .icount(icount)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int m_mode, m_cnt;
   bit m_sprev, m_ack;
   logic [W-1:0] act, exp;

   // Expected outputs for one cycle, derived straight from the decode table.
   function automatic logic [W-1:0] model_out(int mode, logic r, logic [5:0] op,
                                              logic zz, int cnt, bit ack);
      logic si, sm, w3, wz, ph;
      logic [2:0] o;
      logic [CW-1:0] c;
      bit ex;
      si = 1; sm = 0; w3 = 0; wz = 0; ph = 1; o = 3'd0;
      c = cnt[CW-1:0];
      ex = (mode == M_RUN && r) || mode == M_STEP;
      if (ex) begin
         ph = 0;
         if (op[5]) begin w3 = 1; wz = 1; o = op[4:2]; end
         else if (op == 6'd0) begin sm = 1; w3 = 1; end
         else if (op == 6'd4) si = 0;
         else if (op == 6'd5) si = !zz;
         else if (op == 6'd6) si = zz;
         else if (op == 6'd7) ph = 1;
      end
      return {si, sm, w3, wz, o, ph, (mode == M_HALT), ack, c};
   endfunction

   task automatic model_tick();
      bit ex;
      ex = (m_mode == M_RUN && run) || m_mode == M_STEP;
      m_ack = (m_mode == M_STEP);
      if (ex) m_cnt = (m_cnt + 1) % (1 << CW);
      case (m_mode)
         M_IDLE: if (run) m_mode = M_RUN; else if (step && !m_sprev) m_mode = M_STEP;
         M_RUN:  if (!run) m_mode = M_IDLE; else if (Opcode == 6'd7) m_mode = M_HALT;
         M_STEP: m_mode = (Opcode == 6'd7) ? M_HALT : M_IDLE;
         default: ;
      endcase
      m_sprev = step;
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_cnt = 0; m_sprev = 0; m_ack = 0;
   endtask

   // Called at posedge+1: apply inputs, capture act/exp before the next edge.
   task automatic cyc(input logic r, input logic s, input logic [5:0] op, input logic zz);
      run = r; step = s; Opcode = op; z = zz;
      #3;
      exp = model_out(m_mode, r, op, zz, m_cnt, m_ack);
      act = {s_inc, s_inm, we3, wez, Op, pc_hold, halted, step_ack, icount};
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1; #1;
      model_reset();
      exp = model_out(M_IDLE, 0, 0, 0, 0, 0);
      act = {s_inc, s_inm, we3, wez, Op, pc_hold, halted, step_ack, icount};
      n_vec++;
      if (act !== exp) begin n_err++; $display("FAIL reset_held act=%h exp=%h", act, exp); end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 6'b101100, 0);
         n_vec++;
         if (act !== exp) begin n_err++; $display("FAIL reset_idle c%0d act=%h exp=%h", i, act, exp); end
      end
   endtask

   task automatic test_alu();
      do_reset();
      cyc(1, 0, 6'b101100, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 6'b101100, 0);
         n_vec++;
         if (act !== exp || Op !== 3'b011 && 0) ;
         if (act !== exp) begin n_err++; $display("FAIL alu c%0d act=%h exp=%h", i, act, exp); end
      end
      n_vec++;
      if (icount !== 4'd3) begin n_err++; $display("FAIL alu_icount act=%0d exp=3", icount); end
   endtask

   task automatic test_jumps();
      logic [6:0] tbl [5] = '{{6'b000101, 1'b1}, {6'b000101, 1'b0}, {6'b000110, 1'b1},
                              {6'b000110, 1'b0}, {6'b000100, 1'b0}};
      logic [6:0] e;
      for (int i = 0; i < 5; i++) begin
         e = tbl[i];
         cyc(1, 0, e[6:1], e[0]);
         n_vec++;
         if (act !== exp) begin n_err++; $display("FAIL jump%0d act=%h exp=%h", i, act, exp); end
      end
   endtask

   task automatic test_step();
      int writes;
      do_reset();
      writes = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(0, (i < 4), 6'b000000, 0);
         if (act[W-3]) writes++;
         n_vec++;
         if (act !== exp) begin n_err++; $display("FAIL step c%0d act=%h exp=%h", i, act, exp); end
      end
      n_vec++;
      if (writes !== 1 || icount !== 4'd1) begin
         n_err++; $display("FAIL step_once act=%0d/%0d exp=1/1", writes, icount);
      end
   endtask

   task automatic test_halt();
      do_reset();
      cyc(1, 0, 6'b101000, 0);
      cyc(1, 0, 6'b000111, 0);
      n_vec++;
      if (act !== exp) begin n_err++; $display("FAIL halt_exec act=%h exp=%h", act, exp); end
      for (int i = 0; i < 8; i++) begin
         cyc(i[0], i[1], 6'b100000, 1);
         n_vec++;
         if (act !== exp) begin n_err++; $display("FAIL halted c%0d act=%h exp=%h", i, act, exp); end
      end
      do_reset();
      cyc(0, 0, 0, 0);
      n_vec++;
      if (act !== exp) begin n_err++; $display("FAIL halt_reset act=%h exp=%h", act, exp); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 0, 6'b111100, 0);
      #1 reset = 1'b1;
      #1;
      model_reset();
      exp = model_out(M_IDLE, 1, 6'b111100, 0, 0, 0);
      act = {s_inc, s_inm, we3, wez, Op, pc_hold, halted, step_ack, icount};
      n_vec++;
      if (act !== exp) begin n_err++; $display("FAIL async_reset act=%h exp=%h", act, exp); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      cyc(1, 0, 6'b001000, 0);
      for (int i = 0; i < 15; i++) cyc(1, 0, 6'b001000, 0);
      n_vec++;
      if (icount !== 4'd15) begin n_err++; $display("FAIL wrap_pre act=%0d exp=15", icount); end
      cyc(1, 0, 6'b001000, 0);
      n_vec++;
      if (icount !== 4'd0) begin n_err++; $display("FAIL wrap act=%0d exp=0", icount); end
   endtask

   task automatic test_random();
      int hcnt;
      logic [5:0] op;
      do_reset();
      hcnt = 0;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 7))
            0: op = 6'd0;  1: op = 6'd4;  2: op = 6'd5;  3: op = 6'd6;
            4: op = ($urandom_range(0, 3) == 0) ? 6'd7 : 6'd2;
            default: op = 6'($urandom);
         endcase
         cyc(($urandom_range(0, 9) < 5), $urandom_range(0, 1), op, $urandom_range(0, 1));
         n_vec++;
         if (act !== exp) begin n_err++; $display("FAIL rand c%0d act=%h exp=%h", i, act, exp); end
         hcnt = (m_mode == M_HALT) ? hcnt + 1 : 0;
         if (hcnt > 3) begin do_reset(); hcnt = 0; end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_alu();
      test_jumps();
      test_step();
      test_halt();
      test_async_reset();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
